dadda_seq8_ctrl: RTL
====================

DADDA_SEQ8_CTRL -- requirements
Module: dadda_seq8_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-003 Port list, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- product  output  16  unsigned a*b.
- busy  output  1  high in any state other than IDLE.

Function
REQ-004 The block SHALL compute an 8x8 unsigned product by sequencing one internal combinational 4x4 unsigned multiplier over nibble pairs and accumulating the results in a 16-bit register.
REQ-005 FSM states SHALL be IDLE, MUL and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE. An operand pair is accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-007 On accept, the block SHALL:
- latch a and b;
- clear the accumulator and the 2-bit step counter;
- go to MUL, unless a==0 or b==0 (see REQ-010).
REQ-008 In MUL, one step SHALL execute per cycle and add to the accumulator:
- step 0: a[3:0]*b[3:0] << 0
- step 1: a[3:0]*b[7:4] << 4
- step 2: a[7:4]*b[3:0] << 4
- step 3: a[7:4]*b[7:4] << 8
All additions SHALL be 16-bit. Overflow cannot occur and SHALL NOT be flagged.
REQ-009 After step 3, the FSM SHALL go to DONE. out_valid SHALL first be high 5 cycles after the accept edge (accept in cycle T gives out_valid in cycle T+5).
REQ-010 Zero skip: if the accepted a==0 or b==0, the FSM SHALL go directly to DONE with the accumulator at 0, giving out_valid in cycle T+1.
REQ-011 In DONE:
- out_valid SHALL be 1 and product SHALL equal the accumulator.
- product SHALL hold stable while out_ready=0.
REQ-012 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE. in_ready SHALL be 1 in the following cycle, with no same-cycle re-accept. Maximum throughput is one result per 6 cycles (per 2 cycles when zero skip applies).
REQ-013 Outside DONE, product SHALL drive 0 and out_valid SHALL be 0.
REQ-014 While not in IDLE, in_valid, a and b SHALL be ignored, and the latched operands SHALL NOT change.
REQ-015 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-016 The step counter SHALL advance only in MUL and SHALL NOT wrap into a fifth step.

Reset
REQ-017 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the accumulator, step counter and latched operands. The next cycle's outputs SHALL be in_ready=1, out_valid=0, busy=0, product=0.
REQ-018 A reset in MUL or DONE SHALL abort the operation; the pending result SHALL be discarded and never presented.
REQ-019 in_valid SHALL be ignored on any edge where rst_n=0.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- a=0xFF, b=0xFF accepted at cycle T -> out_valid=1, product=0xFE01 at T+5; busy=1 from T+1 through T+5.
- a=0x12, b=0x34 with out_ready held 0 for 3 cycles after out_valid -> product=0x03A8 held stable 4 cycles; in_ready=1 the cycle after the handshake.
- a=0x00, b=0xAB accepted at T -> out_valid=1, product=0x0000 at T+1; same result for a=0x5C, b=0x00.
- in_valid=1 with new operands during MUL -> ignored, in_ready=0; the original product (e.g. 0x0F*0x10=0x00F0) is delivered unchanged.
- rst_n=0 for one edge during step 2 of 0xAA*0x55 -> the next cycle shows IDLE outputs, no out_valid ever appears for that pair, and a new pair 0x03*0x07 yields 0x0015.
- Back-to-back: two accepted pairs with out_ready tied to 1 -> results in order, out_valid spacing exactly 6 cycles.

Source files
------------

// File: rtl/dadda_seq8_ctrl.sv
// dadda_seq8_ctrl: sequential 8x8 unsigned multiplier.
// A single combinational 4x4 multiplier is stepped over the four nibble pairs of the
// latched operands; each partial product is shifted into place and accumulated in a
// 16-bit register. If either operand is zero, the block skips straight to DONE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   block can accept operands (IDLE only)
//   a, b       8-bit unsigned operands
//   out_valid  product available (DONE only)
//   out_ready  consumer accepts product
//   product    16-bit unsigned a*b, 0 outside DONE
//   busy       high in any state other than IDLE
module dadda_seq8_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [3:0]  shamt;
    logic [15:0] pp_shifted;

    // Step bit 1 selects the high nibble of a, bit 0 the high nibble of b:
    // 0: lo*lo, 1: lo*hi, 2: hi*lo, 3: hi*hi.
    always_comb begin
        nib_a      = step_q[1] ? a_q[7:4] : a_q[3:0];
        nib_b      = step_q[0] ? b_q[7:4] : b_q[3:0];
        pp         = {4'b0000, nib_a} * {4'b0000, nib_b};
        // Shift is 4 per high nibble used: 0, 4, 4, 8.
        shamt      = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 2'b00};
        pp_shifted = {8'h00, pp} << shamt;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = 16'h0000;
                    step_d = 2'd0;
                    // Zero operand: result is already 0 in the cleared accumulator.
                    state_d = ((a == 8'h00) || (b == 8'h00)) ? StDone : StMul;
                end
            end
            StMul: begin
                acc_d = acc_q + pp_shifted;
                if (step_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        product   = (state_q == StDone) ? acc_q : 16'h0000;
    end

endmodule
